// File: rtl/mdu_sequencer_if.sv
// Pipeline-side bundle for the iterative multiply/divide unit.
interface mdu_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [4:0]      aluop;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [4:0]      dest_reg;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      result_reg;

  // EX stage / control unit side
  modport master (
    output start, aluop, operand_a, operand_b, dest_reg, flush,
    input  busy, stall, result_valid, result, result_reg
  );

  // Multiply/divide unit side
  modport slave (
    input  start, aluop, operand_a, operand_b, dest_reg, flush,
    output busy, stall, result_valid, result, result_reg
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: one op at a time, 32 iterations,
// pipeline held via stall until the single-cycle result_valid pulse.
module mdu_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic           clk,
  input  logic           resetn,
  mdu_sequencer_if.slave bus
);
  localparam int unsigned      PW       = 2 * XLEN;
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_ITER  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [4:0]       dest_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [XLEN-1:0]  acc_hi;
  logic [XLEN-1:0]  acc_lo;
  logic             neg_q;

  logic             accept;
  logic             is_div;
  logic             div_signed;
  logic             sa;
  logic             sb;
  logic             neg_c;
  logic [XLEN-1:0]  abs_a;
  logic [XLEN-1:0]  abs_b;
  logic             b_zero;
  logic             ovf;
  logic             special;
  logic [XLEN-1:0]  special_val;
  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    div_shift;
  logic             div_ge;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    prod_s;
  logic [XLEN-1:0]  quo_s;
  logic [XLEN-1:0]  rem_s;
  logic [XLEN-1:0]  fix_val;

  assign accept = (state == S_IDLE) && bus.start && (bus.aluop[4:3] == 2'b01) && !bus.flush;

  // Operand conditioning, special-case detection and per-iteration arithmetic
  always_comb begin
    is_div      = op_q[2];
    div_signed  = op_q[2] && !op_q[0];
    sa          = ((op_q == OP_MULH) || (op_q == OP_MULHSU) || div_signed) && a_q[XLEN-1];
    sb          = ((op_q == OP_MULH) || div_signed) && b_q[XLEN-1];
    abs_a       = sa ? -a_q : a_q;
    abs_b       = sb ? -b_q : b_q;
    // remainder takes the dividend's sign, everything else the product of signs
    neg_c       = (op_q[2] && op_q[1]) ? sa : (sa ^ sb);
    b_zero      = (b_q == '0);
    ovf         = div_signed && (a_q == MIN_NEG) && (b_q == '1);
    special     = is_div && (b_zero || ovf);
    special_val = '0;
    if (b_zero) begin
      special_val = op_q[1] ? a_q : '1;
    end else if (ovf) begin
      special_val = op_q[1] ? '0 : MIN_NEG;
    end
    mul_sum     = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? a_q : '0)};
    div_shift   = {acc_hi, acc_lo[XLEN-1]};
    div_ge      = (div_shift >= {1'b0, b_q});
    prod        = {acc_hi, acc_lo};
    prod_s      = neg_q ? -prod : prod;
    quo_s       = neg_q ? -acc_lo : acc_lo;
    rem_s       = neg_q ? -acc_hi : acc_hi;
    case (op_q)
      OP_MUL:                 fix_val = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_s[PW-1:XLEN];
      3'b100, 3'b101:         fix_val = quo_s;
      default:                fix_val = rem_s;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and combinational stall
  always_comb begin
    state_nxt = state;
    bus.stall = 1'b0;
    case (state)
      S_IDLE: begin
        bus.stall = accept && resetn;
        if (accept) state_nxt = S_PREP;
      end
      S_PREP: begin
        bus.stall = 1'b1;
        if (bus.flush)    state_nxt = S_IDLE;
        else if (special) state_nxt = S_DONE;
        else              state_nxt = S_ITER;
      end
      S_ITER: begin
        bus.stall = 1'b1;
        if (bus.flush)            state_nxt = S_IDLE;
        else if (cnt == LAST_CNT) state_nxt = S_FIXUP;
      end
      S_FIXUP: begin
        bus.stall = 1'b1;
        state_nxt = bus.flush ? S_IDLE : S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt              <= '0;
      op_q             <= '0;
      dest_q           <= '0;
      a_q              <= '0;
      b_q              <= '0;
      acc_hi           <= '0;
      acc_lo           <= '0;
      neg_q            <= 1'b0;
      bus.busy         <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.result       <= '0;
      bus.result_reg   <= '0;
    end else begin
      bus.busy         <= (state_nxt != S_IDLE);
      bus.result_valid <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= bus.aluop[2:0];
            dest_q <= bus.dest_reg;
            a_q    <= bus.operand_a;
            b_q    <= bus.operand_b;
          end
        end
        S_PREP: begin
          a_q    <= abs_a;
          b_q    <= abs_b;
          neg_q  <= neg_c;
          acc_hi <= '0;
          acc_lo <= is_div ? abs_a : abs_b;
          cnt    <= '0;
          if (state_nxt == S_DONE) begin
            bus.result     <= special_val;
            bus.result_reg <= dest_q;
          end
        end
        S_ITER: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div) begin
            acc_hi <= div_ge ? (div_shift[XLEN-1:0] - b_q) : div_shift[XLEN-1:0];
            acc_lo <= {acc_lo[XLEN-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[XLEN:1];
            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
          end
        end
        S_FIXUP: begin
          if (state_nxt == S_DONE) begin
            bus.result     <= fix_val;
            bus.result_reg <= dest_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed vector table, hand-written
// flush/reset/start corner sequences and randomized ops against a reference model.
module tb_mdu_sequencer;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mdu_sequencer_if #(.XLEN(32)) bus ();

  mdu_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference results straight from the RV32M definitions
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && (b == 0)) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.aluop     = 5'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.dest_reg  = '0;
    bus.flush     = 1'b0;
  endtask

  // Issue one op at cycle N and track stall / pulse timing until completion
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    bit seen;
    bit stall_ok;
    int lat;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.aluop     = {2'b01, op};
    bus.operand_a = a;
    bus.operand_b = b;
    bus.dest_reg  = rd;
    #1 check({name, " stall@N"}, 32'(bus.stall), 32'd1);
    seen     = 1'b0;
    stall_ok = 1'b1;
    lat      = 0;
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      @(negedge clk);
      bus.start     = 1'b0;
      bus.operand_a = $urandom();
      bus.operand_b = $urandom();
      bus.dest_reg  = 5'($urandom());
      #1;
      if (bus.result_valid) begin
        seen = 1'b1;
        lat  = cyc;
        check({name, " result"}, bus.result, exp_res);
        check({name, " result_reg"}, 32'(bus.result_reg), 32'(rd));
        check({name, " stall@done"}, 32'(bus.stall), 32'd0);
      end else if (!bus.stall || !bus.busy) begin
        stall_ok = 1'b0;
      end
    end
    check({name, " pulse seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " stall held"}, 32'(stall_ok), 32'd1);
    @(negedge clk);
    #1;
    check({name, " pulse width"}, 32'(bus.result_valid), 32'd0);
    check({name, " idle after"}, 32'(bus.busy), 32'd0);
    check({name, " result hold"}, bus.result, exp_res);
    last_res = exp_res;
  endtask

  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      #1;
      if (bus.result_valid) pulses++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [2:0] op;
    logic [31:0] a, b;
    int mode;

    drive_idle();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset stall", 32'(bus.stall), 32'd0);
    check("reset valid", 32'(bus.result_valid), 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset result_reg", 32'(bus.result_reg), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    vecs[0]  = '{3'd0, 32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 35};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 35};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 35};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 35};
    vecs[4]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0001, 35};
    vecs[5]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, 35};
    vecs[6]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF, 35};
    vecs[7]  = '{3'd5, 32'd100,      32'd7,         5'd10, 32'd14,        35};
    vecs[8]  = '{3'd7, 32'd100,      32'd7,         5'd11, 32'd2,         35};
    vecs[9]  = '{3'd5, 32'd5,        32'd0,         5'd12, 32'hFFFF_FFFF, 2};
    vecs[10] = '{3'd6, 32'd5,        32'd0,         5'd13, 32'd5,         2};
    vecs[11] = '{3'd4, MIN_NEG,      32'hFFFF_FFFF, 5'd14, MIN_NEG,       2};
    vecs[12] = '{3'd6, MIN_NEG,      32'hFFFF_FFFF, 5'd15, 32'd0,         2};
    vecs[13] = '{3'd4, 32'd0,        32'd0,         5'd31, 32'hFFFF_FFFF, 2};

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].res, vecs[i].lat);

    // Flush in ITER at N+10
    @(negedge clk);
    bus.start = 1'b1; bus.aluop = 5'b01101; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
    bus.dest_reg = 5'd9;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 10) bus.flush = 1'b1;
    end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush busy", 32'(bus.busy), 32'd0);
    check("flush stall", 32'(bus.stall), 32'd0);
    count_pulses(40, pulses);
    check("flush no pulse", 32'(pulses), 32'd0);
    check("flush result kept", bus.result, last_res);

    // START with FLUSH in the same cycle is not accepted
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.aluop = 5'b01000;
    #1 check("start+flush stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    drive_idle();
    #1 check("start+flush busy", 32'(bus.busy), 32'd0);

    // Non-M ALUOP values are ignored
    @(negedge clk);
    bus.start = 1'b1; bus.aluop = 5'b00000;
    #1 check("non-M stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.aluop = 5'b10100;
    #1 check("non-M busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    drive_idle();
    #1 check("non-M busy 2", 32'(bus.busy), 32'd0);

    // START during ITER is ignored; only the first op completes
    @(negedge clk);
    bus.start = 1'b1; bus.aluop = 5'b01100; bus.operand_a = 32'hFFFF_FFF9; bus.operand_b = 32'd2;
    bus.dest_reg = 5'd21;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k < 5) begin
        bus.start = 1'b0;
      end else begin
        bus.start = 1'b1; bus.aluop = 5'b01000; bus.operand_a = 32'd3; bus.operand_b = 32'd3;
        bus.dest_reg = 5'd22;
      end
    end
    drive_idle();
    count_pulses(50, pulses);
    check("start in iter pulses", 32'(pulses), 32'd1);
    check("start in iter result", bus.result, 32'hFFFF_FFFD);
    check("start in iter rd", 32'(bus.result_reg), 32'd21);

    // Reset mid-op at N+5
    @(negedge clk);
    bus.start = 1'b1; bus.aluop = 5'b01011; bus.operand_a = 32'd12345; bus.operand_b = 32'd678;
    bus.dest_reg = 5'd17;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    resetn = 1'b0;
    #1;
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset stall", 32'(bus.stall), 32'd0);
    check("midreset valid", 32'(bus.result_valid), 32'd0);
    check("midreset result", bus.result, 32'd0);
    check("midreset result_reg", 32'(bus.result_reg), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    count_pulses(40, pulses);
    check("midreset no pulse", 32'(pulses), 32'd0);
    last_res = '0;

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      op   = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 7);
      a    = $urandom();
      b    = $urandom();
      case (mode)
        0: b = '0;
        1: begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        3: begin a = -32'($urandom_range(0, 300)); b = $urandom_range(1, 20); end
        4: begin a = $urandom_range(0, 300); b = -32'($urandom_range(1, 20)); end
        default: ;
      endcase
      run_op($sformatf("rand%0d op%0d", i, op), op, a, b, 5'($urandom()),
             ref_result(op, a, b), ref_latency(op, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
